// File: rtl/sid_pkg.sv
// Shared SID types: chip model, phase strobes, waveform inputs, noise writeback, float TTLs.
package sid;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  localparam int unsigned NumPhases = 4;
  localparam int unsigned PHI1      = 0;

  typedef logic [NumPhases-1:0] phase_t;

  typedef struct packed {
    logic [3:0]  selector;  // {noise, pulse, saw, tri}
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
  } waveform_i_t;

  typedef struct packed {
    logic       en;
    logic [7:0] bits;
  } noise_wb_t;

  localparam logic [23:0] FLOAT_TTL_6581_DEFAULT = 24'h004000;
  localparam logic [23:0] FLOAT_TTL_8580_DEFAULT = 24'h200000;

  // Unselected waveforms contribute all-ones so they drop out of the AND.
  function automatic logic [11:0] combine_waveforms(input waveform_i_t w);
    logic [11:0] acc;
    acc = 12'hfff;
    if (w.selector[0]) acc &= {w.saw_tri[10:0], 1'b0};
    if (w.selector[1]) acc &= w.saw_tri;
    if (w.selector[2]) acc &= {12{w.pulse}};
    if (w.selector[3]) acc &= {w.noise, 4'b0000};
    return acc;
  endfunction

endpackage

// File: rtl/sid_float_hold.sv
// Counts PHI1 strobes spent with no waveform selected; flags when the hold time runs out.
// Instantiated only when SID_WAVEFORM_FLOAT_EN is defined.
module sid_float_hold (
  input  logic        clk,
  input  logic        res_n,
  input  logic        tick,
  input  logic        clear,
  input  logic [23:0] ttl,
  output logic        expired
);

  logic [23:0] count_q, count_d;
  logic [24:0] count_inc;

  assign count_inc = {1'b0, count_q} + 25'd1;

  // Compare the post-increment count so a lowered TTL still expires on the next tick.
  assign expired = tick && (count_inc >= {1'b0, ttl});

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != '1)) begin
      count_d = count_inc[23:0];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sid_waveform_mixer.sv
// Combines selected SID waveforms by bitwise AND, registered on PHI1, with noise writeback.
// Define SID_WAVEFORM_FLOAT_EN to hold a deselected output for the model's float TTL.
module sid_waveform_mixer
  import sid::*;
#(
  parameter logic [23:0] FLOAT_TTL_6581 = FLOAT_TTL_6581_DEFAULT,
  parameter logic [23:0] FLOAT_TTL_8580 = FLOAT_TTL_8580_DEFAULT
) (
  input  logic        clk,
  input  logic        res_n,
  input  model_e      model,
  input  phase_t      phase,
  input  waveform_i_t wav_i,
  output logic [11:0] wav_o,
  output noise_wb_t   noise_wb
);

  logic        phi1;
  logic        sel_none;
  logic        float_zero;
  logic [11:0] comb;
  logic [11:0] wav_q, wav_d;
  noise_wb_t   nwb_q, nwb_d;
  logic        unused_phase;

  assign phi1         = phase[PHI1];
  assign sel_none     = (wav_i.selector == 4'b0000);
  assign comb         = combine_waveforms(wav_i);
  assign unused_phase = ^phase;

`ifdef SID_WAVEFORM_FLOAT_EN
  logic [23:0] ttl;
  logic        expired;

  assign ttl = (model == MOS6581) ? FLOAT_TTL_6581 : FLOAT_TTL_8580;

  sid_float_hold u_float_hold (
    .clk     (clk),
    .res_n   (res_n),
    .tick    (phi1 && sel_none),
    .clear   (phi1 && !sel_none),
    .ttl     (ttl),
    .expired (expired)
  );

  assign float_zero = expired;
`else
  logic unused_cfg;

  assign unused_cfg = ^{model, FLOAT_TTL_6581, FLOAT_TTL_8580};
  assign float_zero = 1'b1;
`endif

  always_comb begin
    wav_d = wav_q;
    if (!sel_none) begin
      wav_d = comb;
    end else if (float_zero) begin
      wav_d = 12'h000;
    end
    nwb_d.en   = wav_i.selector[3] && (wav_i.selector[2:0] != 3'b000);
    nwb_d.bits = nwb_d.en ? wav_d[11:4] : 8'hff;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wav_q <= 12'h000;
      nwb_q <= '{en: 1'b0, bits: 8'hff};
    end else if (phi1) begin
      wav_q <= wav_d;
      nwb_q <= nwb_d;
    end
  end

  assign wav_o    = wav_q;
  assign noise_wb = nwb_q;

endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Scoreboard bench for sid_waveform_mixer against a behavioural model of the mixing rules.
module tb_sid_waveform_mixer;
  import sid::*;

  localparam logic [23:0] Ttl6581 = 24'd8;
  localparam logic [23:0] Ttl8580 = 24'd20;
`ifdef SID_WAVEFORM_FLOAT_EN
  localparam bit FloatEn = 1'b1;
`else
  localparam bit FloatEn = 1'b0;
`endif

  logic        clk;
  logic        res_n;
  model_e      model;
  phase_t      phase;
  waveform_i_t wav_i;
  logic [11:0] wav_o;
  noise_wb_t   noise_wb;

  sid_waveform_mixer #(
    .FLOAT_TTL_6581 (Ttl6581),
    .FLOAT_TTL_8580 (Ttl8580)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .model    (model),
    .phase    (phase),
    .wav_i    (wav_i),
    .wav_o    (wav_o),
    .noise_wb (noise_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  logic [11:0] q_wav[$];
  logic [8:0]  q_nwb[$];

  // Reference model state
  int          m_wav;
  int          m_en;
  int          m_bits;
  longint      m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int mix(input int sel, input int n, input int p, input int st);
    int acc;
    acc = 4095;
    if (sel % 2 == 1)       acc = acc & ((st * 2) % 4096);
    if ((sel / 2) % 2 == 1) acc = acc & st;
    if ((sel / 4) % 2 == 1) acc = acc & (p != 0 ? 4095 : 0);
    if ((sel / 8) % 2 == 1) acc = acc & (n * 16);
    return acc;
  endfunction

  task automatic model_reset();
    m_wav  = 0;
    m_en   = 0;
    m_bits = 255;
    m_cnt  = 0;
  endtask

  task automatic step(input logic [3:0] sel, input logic [7:0] n, input logic p,
                      input logic [11:0] st, input model_e m, input bit phi);
    phase_t ph;
    longint ttl;
    @(negedge clk);
    ph = '0;
    if (phi) ph[PHI1] = 1'b1;
    else     ph[(PHI1 + 1 + $urandom_range(0, NumPhases - 2)) % NumPhases] = 1'b1;
    wav_i = '{selector: sel, noise: n, pulse: p, saw_tri: st};
    model = m;
    phase = ph;
    if (phi) begin
      ttl = (m == MOS6581) ? longint'(Ttl6581) : longint'(Ttl8580);
      if (sel != 0) begin
        m_cnt = 0;
        m_wav = mix(int'(sel), int'(n), int'(p), int'(st));
      end else begin
        m_cnt++;
        if (!FloatEn || m_cnt >= ttl) m_wav = 0;
      end
      m_en   = (sel[3] && sel[2:0] != 0) ? 1 : 0;
      m_bits = (m_en != 0) ? (m_wav / 16) : 255;
    end
    q_wav.push_back(12'(m_wav));
    q_nwb.push_back({1'(m_en), 8'(m_bits)});
    pushes++;
  endtask

  // One PHI1 strobe followed by a non-PHI1 cycle with identical inputs.
  task automatic phi1_pair(input logic [3:0] sel, input logic [11:0] st, input model_e m);
    logic [7:0] n;
    logic       p;
    n = 8'($urandom);
    p = 1'($urandom);
    step(sel, n, p, st, m, 1'b1);
    step(sel, n, p, st, m, 1'b0);
  endtask

  // Monitor: every clock is an output event; compare against the oldest expectation.
  initial begin
    logic [11:0] ew;
    logic [8:0]  en;
    forever begin
      @(posedge clk);
      #2;
      if (q_wav.size() != 0) begin
        ew = q_wav.pop_front();
        en = q_nwb.pop_front();
        pops++;
        chk("wav_o", 32'(wav_o), 32'(ew));
        chk("noise_wb", 32'(noise_wb), 32'(en));
      end
    end
  end

  initial begin
    model_reset();
    res_n = 1'b0;
    model = MOS6581;
    phase = '0;
    wav_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wav_o", 32'(wav_o), 32'h000);
    chk("reset_noise_wb", 32'(noise_wb), 32'h0ff);
    @(negedge clk);
    res_n = 1'b1;

    // Saw only, then tri+saw
    phi1_pair(4'b0010, 12'hA5C, MOS6581);
    step(4'b0010, 8'h00, 1'b0, 12'hA5C, MOS6581, 1'b0);
    step(4'b0001, 8'h00, 1'b0, 12'h123, MOS6581, 1'b0);
    phi1_pair(4'b0011, 12'hF0F, MOS6581);

    // Noise+pulse, then with pulse low
    step(4'b1100, 8'hC3, 1'b1, 12'h000, MOS6581, 1'b1);
    step(4'b1100, 8'hC3, 1'b1, 12'h000, MOS6581, 1'b0);
    step(4'b1100, 8'hC3, 1'b0, 12'h000, MOS6581, 1'b1);
    step(4'b1100, 8'hC3, 1'b0, 12'h000, MOS6581, 1'b0);
    step(4'b1111, 8'hFF, 1'b1, 12'hFFF, MOS6581, 1'b1);
    step(4'b1000, 8'h5A, 1'b0, 12'h000, MOS6581, 1'b1);
    step(4'b0100, 8'h00, 1'b1, 12'h000, MOS6581, 1'b1);

    // Float expiry on the 6581
    phi1_pair(4'b0010, 12'h7FF, MOS6581);
    repeat (10) phi1_pair(4'b0000, 12'($urandom), MOS6581);

    // Reselect on the expiring strobe
    phi1_pair(4'b0010, 12'h7FF, MOS6581);
    repeat (7) phi1_pair(4'b0000, 12'($urandom), MOS6581);
    phi1_pair(4'b0011, 12'h0F0, MOS6581);

    // Model change mid-float: counter already past the 6581 TTL
    phi1_pair(4'b0010, 12'h7FF, MOS8580);
    repeat (10) phi1_pair(4'b0000, 12'($urandom), MOS8580);
    phi1_pair(4'b0000, 12'($urandom), MOS6581);

    // Asynchronous reset mid-float
    phi1_pair(4'b1010, 12'hFFF, MOS6581);
    repeat (3) phi1_pair(4'b0000, 12'($urandom), MOS6581);
    @(posedge clk);
    #3;
    res_n = 1'b0;
    #1;
    chk("async_reset_wav_o", 32'(wav_o), 32'h000);
    chk("async_reset_en", 32'(noise_wb.en), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    res_n = 1'b1;
    repeat (5) phi1_pair(4'b0000, 12'($urandom), MOS6581);

    // Randomised traffic with bursts of deselection
    for (int i = 0; i < 600; i++) begin
      logic [3:0] sel;
      sel = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom);
      step(sel, 8'($urandom), 1'($urandom), 12'($urandom),
           ($urandom_range(0, 19) == 0) ? MOS8580 : MOS6581,
           $urandom_range(0, 2) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(pops), 32'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
